// File: rtl/unidade_busca_instrucao.sv
// Instruction-fetch sequencer: owns the PC, reads the single-cycle instruction ROM,
// buffers up to two {pc, instrucao} pairs for decode and applies branch/jump redirects.
module unidade_busca_instrucao #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_instrucao,
    input  logic        desvio_valido,
    input  logic [31:0] desvio_alvo,
    output logic        inst_valida,
    input  logic        inst_pronta,
    output logic [31:0] instrucao,
    output logic [31:0] pc_inst,
    output logic        erro
);

    localparam logic [31:0] LIMITE = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        PARADO,
        BUSCANDO,
        ERRO
    } estado_t;

    estado_t     estado;
    logic [31:0] pc;
    logic [31:0] buf_pc   [2];
    logic [31:0] buf_inst [2];
    logic        head;
    logic [1:0]  count;

    logic        desvio;
    logic        alvo_legal;
    logic        pop;
    logic        push;
    logic        tail;
    logic [31:0] pc_mais4;
    logic [31:0] pc_prox;

    // Redirects are dead once trapped; only the reset can leave ERRO.
    assign desvio     = desvio_valido && (estado != ERRO);
    assign alvo_legal = (desvio_alvo[1:0] == 2'b00) && (desvio_alvo < LIMITE);

    assign inst_valida = (count != 2'd0) && (estado != ERRO);
    assign pop         = inst_valida && inst_pronta;
    assign push        = (estado == BUSCANDO) && !desvio && ((count != 2'd2) || pop);

    // With a full buffer the tail slot is the head slot, which the same-cycle pop frees.
    assign tail     = head ^ count[0];
    assign pc_mais4 = pc + 32'd4;
    assign pc_prox  = (pc_mais4 == LIMITE) ? 32'h0 : pc_mais4;

    assign mem_addr  = pc;
    assign instrucao = inst_valida ? buf_inst[head] : 32'h0;
    assign pc_inst   = inst_valida ? buf_pc[head]   : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= PARADO;
            pc     <= PC_RESET;
            head   <= 1'b0;
            count  <= 2'd0;
            erro   <= 1'b0;
        end else begin
            case (estado)
                PARADO: begin
                    if (desvio && !alvo_legal) begin
                        estado <= ERRO;
                    end else if (en) begin
                        estado <= BUSCANDO;
                    end
                end
                BUSCANDO: begin
                    if (desvio && !alvo_legal) begin
                        estado <= ERRO;
                    end else if (!en) begin
                        estado <= PARADO;
                    end
                end
                ERRO: begin
                    estado <= ERRO;
                end
                default: begin
                    estado <= PARADO;
                end
            endcase

            // A redirect wins over push and pop: any concurrent pop is dropped with the flush.
            if (desvio) begin
                count <= 2'd0;
                head  <= 1'b0;
                if (alvo_legal) begin
                    pc <= desvio_alvo;
                end else begin
                    erro <= 1'b1;
                end
            end else if (estado == ERRO) begin
                count <= 2'd0;
            end else begin
                if (push) begin
                    buf_pc[tail]   <= pc;
                    buf_inst[tail] <= mem_instrucao;
                    pc             <= pc_prox;
                end
                if (pop) begin
                    head <= ~head;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_unidade_busca_instrucao.sv
// Self-checking bench for unidade_busca_instrucao: ROM word[i]=i, a scoreboard of expected
// delivered PCs consumed by a handshake monitor, plus per-scenario inline checks.
module tb_unidade_busca_instrucao;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] mem_addr;
    logic [31:0] mem_instrucao;
    logic        desvio_valido;
    logic [31:0] desvio_alvo;
    logic        inst_valida;
    logic        inst_pronta;
    logic [31:0] instrucao;
    logic [31:0] pc_inst;
    logic        erro;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    logic [31:0] mon_exp;

    unidade_busca_instrucao #(
        .PC_RESET (32'h0000_0000),
        .MEM_BYTES(256)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .mem_addr     (mem_addr),
        .mem_instrucao(mem_instrucao),
        .desvio_valido(desvio_valido),
        .desvio_alvo  (desvio_alvo),
        .inst_valida  (inst_valida),
        .inst_pronta  (inst_pronta),
        .instrucao    (instrucao),
        .pc_inst      (pc_inst),
        .erro         (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: word i holds the value i.
    assign mem_instrucao = {2'b00, mem_addr[31:2]};

    // An accepted handshake (not discarded by a redirect) must deliver the scoreboard head.
    always @(negedge clk) begin
        if (!reset && inst_valida && inst_pronta && !desvio_valido) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_delivery pc_inst=%h required=none", pc_inst);
            end else begin
                mon_exp = sb.pop_front();
                if (pc_inst !== mon_exp || instrucao !== {2'b00, mon_exp[31:2]}) begin
                    errors++;
                    $display("[TB] FAIL delivery pc_inst=%h instrucao=%h required pc=%h inst=%h",
                             pc_inst, instrucao, mon_exp, {2'b00, mon_exp[31:2]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        en            = 1'b0;
        inst_pronta   = 1'b0;
        desvio_valido = 1'b0;
        desvio_alvo   = 32'h0;
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_leftover pending=%0d required=0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mem_addr !== 32'h0 || inst_valida !== 1'b0 || instrucao !== 32'h0 ||
            pc_inst !== 32'h0 || erro !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values addr=%h valida=%b inst=%h pc=%h erro=%b required 0/0/0/0/0",
                     mem_addr, inst_valida, instrucao, pc_inst, erro);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 12; i++) sb.push_back(32'(i * 4));
        en          = 1'b1;
        inst_pronta = 1'b1;
        tick();
        checks++;
        if (inst_valida !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_latency valida=%b required=0", inst_valida);
        end
        tick();
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (inst_valida !== 1'b1 || pc_inst !== 32'(k * 4)) begin
                errors++;
                $display("[TB] FAIL stream_pc valida=%b pc_inst=%h required=%h",
                         inst_valida, pc_inst, 32'(k * 4));
            end
            tick();
        end
        inst_pronta = 1'b0;
        check_sb_empty("stream");
    endtask

    task automatic test_backpressure();
        do_reset();
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
        en = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (inst_valida !== 1'b1 || pc_inst !== 32'h0) begin
                errors++;
                $display("[TB] FAIL stall_head valida=%b pc_inst=%h required=00000000",
                         inst_valida, pc_inst);
            end
        end
        checks++;
        if (mem_addr !== 32'h8) begin
            errors++;
            $display("[TB] FAIL stall_addr mem_addr=%h required=00000008", mem_addr);
        end
        inst_pronta = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pc_inst !== 32'(k * 4)) begin
                errors++;
                $display("[TB] FAIL release_pc pc_inst=%h required=%h", pc_inst, 32'(k * 4));
            end
            tick();
        end
        inst_pronta = 1'b0;
        check_sb_empty("backpressure");
    endtask

    task automatic test_redirect();
        do_reset();
        en = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (mem_addr !== 32'h8 || pc_inst !== 32'h0) begin
            errors++;
            $display("[TB] FAIL redirect_setup addr=%h pc_inst=%h required 8/0", mem_addr, pc_inst);
        end
        sb.push_back(32'h40);
        sb.push_back(32'h44);
        desvio_valido = 1'b1;
        desvio_alvo   = 32'h40;
        inst_pronta   = 1'b1;
        tick();
        desvio_valido = 1'b0;
        checks++;
        if (inst_valida !== 1'b0 || mem_addr !== 32'h40) begin
            errors++;
            $display("[TB] FAIL redirect_flush valida=%b addr=%h required 0/40", inst_valida, mem_addr);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (inst_valida !== 1'b1 || pc_inst !== 32'(32'h40 + k * 4)) begin
                errors++;
                $display("[TB] FAIL redirect_target valida=%b pc_inst=%h required=%h",
                         inst_valida, pc_inst, 32'(32'h40 + k * 4));
            end
            tick();
        end
        inst_pronta = 1'b0;
        check_sb_empty("redirect");
    endtask

    task automatic test_wrap();
        logic [31:0] seq [6];
        seq = '{32'hF0, 32'hF4, 32'hF8, 32'hFC, 32'h0, 32'h4};
        do_reset();
        desvio_valido = 1'b1;
        desvio_alvo   = 32'hF0;
        tick();
        desvio_valido = 1'b0;
        for (int i = 0; i < 6; i++) sb.push_back(seq[i]);
        en          = 1'b1;
        inst_pronta = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (inst_valida !== 1'b1 || pc_inst !== seq[k]) begin
                errors++;
                $display("[TB] FAIL wrap_pc valida=%b pc_inst=%h required=%h",
                         inst_valida, pc_inst, seq[k]);
            end
            tick();
        end
        inst_pronta = 1'b0;
        en          = 1'b0;
        check_sb_empty("wrap");
    endtask

    task automatic test_illegal();
        logic [31:0] alvos [2];
        alvos = '{32'h42, 32'h100};
        for (int t = 0; t < 2; t++) begin
            do_reset();
            en          = 1'b1;
            inst_pronta = 1'b1;
            tick();
            tick();
            desvio_valido = 1'b1;
            desvio_alvo   = alvos[t];
            tick();
            checks++;
            if (erro !== 1'b1 || inst_valida !== 1'b0 || instrucao !== 32'h0 ||
                pc_inst !== 32'h0 || mem_addr !== 32'h4) begin
                errors++;
                $display("[TB] FAIL trap alvo=%h erro=%b valida=%b inst=%h pc=%h addr=%h required 1/0/0/0/4",
                         alvos[t], erro, inst_valida, instrucao, pc_inst, mem_addr);
            end
            desvio_alvo = 32'h40;
            tick();
            desvio_valido = 1'b0;
            tick();
            checks++;
            if (erro !== 1'b1 || inst_valida !== 1'b0 || mem_addr !== 32'h4) begin
                errors++;
                $display("[TB] FAIL trap_sticky erro=%b valida=%b addr=%h required 1/0/4",
                         erro, inst_valida, mem_addr);
            end
            inst_pronta = 1'b0;
            reset       = 1'b1;
            tick();
            reset = 1'b0;
            checks++;
            if (erro !== 1'b0 || mem_addr !== 32'h0 || inst_valida !== 1'b0) begin
                errors++;
                $display("[TB] FAIL trap_clear erro=%b addr=%h valida=%b required 0/0/0",
                         erro, mem_addr, inst_valida);
            end
            check_sb_empty("illegal");
        end
    endtask

    task automatic test_pause_and_reset();
        do_reset();
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
        en          = 1'b1;
        inst_pronta = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (pc_inst !== 32'h4) begin
            errors++;
            $display("[TB] FAIL pause_setup pc_inst=%h required=00000004", pc_inst);
        end
        en          = 1'b0;
        inst_pronta = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (mem_addr !== 32'hC || inst_valida !== 1'b1 || pc_inst !== 32'h4) begin
                errors++;
                $display("[TB] FAIL paused addr=%h valida=%b pc_inst=%h required C/1/4",
                         mem_addr, inst_valida, pc_inst);
            end
        end
        en          = 1'b1;
        inst_pronta = 1'b1;
        tick();
        checks++;
        if (pc_inst !== 32'h8) begin
            errors++;
            $display("[TB] FAIL resume_pc pc_inst=%h required=00000008", pc_inst);
        end
        tick();
        checks++;
        if (pc_inst !== 32'hC) begin
            errors++;
            $display("[TB] FAIL resume_next pc_inst=%h required=0000000c", pc_inst);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (mem_addr !== 32'h0 || inst_valida !== 1'b0 || instrucao !== 32'h0 ||
            pc_inst !== 32'h0 || erro !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midstream_reset addr=%h valida=%b inst=%h pc=%h erro=%b required 0/0/0/0/0",
                     mem_addr, inst_valida, instrucao, pc_inst, erro);
        end
        reset       = 1'b0;
        en          = 1'b0;
        inst_pronta = 1'b0;
        check_sb_empty("pause");
    endtask

    initial begin
        reset         = 1'b1;
        en            = 1'b0;
        inst_pronta   = 1'b0;
        desvio_valido = 1'b0;
        desvio_alvo   = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_illegal();
        test_pause_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
